// File: rtl/riscv_pkg.sv
// Shared encodings for the memory-access stage: load/store opcodes,
// write-back select values and the access FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned STRB_WIDTH     = XLEN / 8;

    localparam logic [2:0] LOAD_NONE = 3'b000;
    localparam logic [2:0] LOAD_LB   = 3'b001;
    localparam logic [2:0] LOAD_LH   = 3'b010;
    localparam logic [2:0] LOAD_LW   = 3'b011;
    localparam logic [2:0] LOAD_LBU  = 3'b100;
    localparam logic [2:0] LOAD_LHU  = 3'b101;

    localparam logic [1:0] STORE_NONE = 2'b00;
    localparam logic [1:0] STORE_SB   = 2'b01;
    localparam logic [1:0] STORE_SH   = 2'b10;
    localparam logic [1:0] STORE_SW   = 2'b11;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // 110 and 111 are not loads
    function automatic logic is_load_op(input logic [2:0] op);
        return op inside {LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU};
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory request/ready handshake between the stage (master) and memory (slave).
interface memory_access_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  DMEM_REQ;
    logic                  DMEM_WE;
    logic [ADDR_WIDTH-1:0] DMEM_ADDR;
    logic [3:0]            DMEM_WSTRB;
    logic [31:0]           DMEM_WDATA;
    logic                  DMEM_READY;
    logic [31:0]           DMEM_RDATA;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WSTRB, DMEM_WDATA,
        input  DMEM_READY, DMEM_RDATA
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WSTRB, DMEM_WDATA,
        output DMEM_READY, DMEM_RDATA
    );
endinterface

// File: rtl/load_align_extend.sv
// Picks the addressed byte/half/word out of the read word and extends it.
module load_align_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      load_op,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection; halves only look at offset[1]
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign or zero extension by load type
    always_comb begin
        load_data_c = '0;
        case (load_op)
            LOAD_LB:  load_data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: load_data_c = {{(XLEN-8){1'b0}}, byte_sel};
            LOAD_LH:  load_data_c = {{(XLEN-16){half_sel[15]}}, half_sel};
            LOAD_LHU: load_data_c = {{(XLEN-16){1'b0}}, half_sel};
            LOAD_LW:  load_data_c = rdata;
            default:  load_data_c = '0;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests, lane-aligns
// stores, extracts loads, stalls upstream while an access is pending and
// registers the write-back result.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently aligning them).
module memory_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [XLEN-1:0]           ALU_OUT,
    input  logic [REG_ADDR_WIDTH-1:0] RD_ADDRESS_IN,
    input  logic [2:0]                DATA_CACHE_LOAD_IN,
    input  logic [1:0]                DATA_CACHE_STORE_IN,
    input  logic [XLEN-1:0]           DATA_CACHE_STORE_DATA,
    input  logic                      WRITE_BACK_MUX_SELECT_IN,
    input  logic                      RD_WRITE_ENABLE_IN,
    memory_access_stage_if.master     dmem,
    output logic                      STALL_PIPELINE,
    output logic                      MISALIGNED_FAULT,
    output logic [REG_ADDR_WIDTH-1:0] RD_ADDRESS_OUT,
    output logic                      RD_WRITE_ENABLE_OUT,
    output logic [XLEN-1:0]           WB_DATA
);

    mem_state_e            state_q;
    mem_state_e            state_d;
    logic [1:0]            offset;
    logic                  is_load;
    logic                  is_store;
    logic                  misaligned;
    logic                  mem_go;
    logic                  load_go;
    logic                  req_c;
    logic                  stall_c;
    logic [STRB_WIDTH-1:0] wstrb_c;
    logic [XLEN-1:0]       wdata_c;
    logic [XLEN-1:0]       load_data_c;

    assign offset = ALU_OUT[1:0];

    // Access decode; a load wins over a simultaneous store
    always_comb begin
        is_load    = is_load_op(DATA_CACHE_LOAD_IN);
        is_store   = !is_load && (DATA_CACHE_STORE_IN != STORE_NONE);
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (is_load) begin
            case (DATA_CACHE_LOAD_IN)
                LOAD_LH, LOAD_LHU: misaligned = offset[0];
                LOAD_LW:           misaligned = (offset != 2'b00);
                default:           misaligned = 1'b0;
            endcase
        end else if (is_store) begin
            case (DATA_CACHE_STORE_IN)
                STORE_SH: misaligned = offset[0];
                STORE_SW: misaligned = (offset != 2'b00);
                default:  misaligned = 1'b0;
            endcase
        end
`endif
        mem_go  = (is_load || is_store) && !misaligned;
        load_go = is_load && !misaligned;
    end

    // Store byte strobes and lane-replicated write data
    always_comb begin
        wstrb_c = '0;
        wdata_c = '0;
        if (is_store) begin
            case (DATA_CACHE_STORE_IN)
                STORE_SB: begin
                    wstrb_c = STRB_WIDTH'(4'b0001 << offset);
                    wdata_c = {4{DATA_CACHE_STORE_DATA[7:0]}};
                end
                STORE_SH: begin
                    wstrb_c = offset[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{DATA_CACHE_STORE_DATA[15:0]}};
                end
                STORE_SW: begin
                    wstrb_c = 4'b1111;
                    wdata_c = DATA_CACHE_STORE_DATA;
                end
                default: begin
                    wstrb_c = '0;
                    wdata_c = '0;
                end
            endcase
        end
    end

    // Access FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= MEM_IDLE;
        else        state_q <= state_d;
    end

    // Access FSM next state, request and stall
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_go) begin
                    req_c = 1'b1;
                    if (!dmem.DMEM_READY) begin
                        state_d = MEM_WAIT;
                        stall_c = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                req_c = 1'b1;
                if (dmem.DMEM_READY) state_d = MEM_IDLE;
                else                 stall_c = 1'b1;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Payload is a function of the frozen inputs, so it holds while waiting;
    // reset kills the request and stall immediately
    assign dmem.DMEM_REQ   = req_c && RST_N;
    assign dmem.DMEM_WE    = req_c && RST_N && is_store;
    assign dmem.DMEM_ADDR  = {ALU_OUT[ADDR_WIDTH-1:2], 2'b00};
    assign dmem.DMEM_WSTRB = wstrb_c;
    assign dmem.DMEM_WDATA = wdata_c;
    assign STALL_PIPELINE  = stall_c && RST_N;

    load_align_extend u_load_align_extend (
        .rdata       (dmem.DMEM_RDATA),
        .offset      (offset),
        .load_op     (DATA_CACHE_LOAD_IN),
        .load_data_c (load_data_c)
    );

    // Write-back registers: bubble while stalled, otherwise retire the instruction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_ADDRESS_OUT      <= '0;
            RD_WRITE_ENABLE_OUT <= 1'b0;
            WB_DATA             <= '0;
            MISALIGNED_FAULT    <= 1'b0;
        end else begin
            MISALIGNED_FAULT <= misaligned;
            if (stall_c) begin
                RD_WRITE_ENABLE_OUT <= 1'b0;
            end else begin
                RD_ADDRESS_OUT      <= RD_ADDRESS_IN;
                RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN && !misaligned;
                WB_DATA             <= (load_go && (WRITE_BACK_MUX_SELECT_IN == WB_SEL_MEM))
                                       ? load_data_c : ALU_OUT;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomised scoreboard bench for memory_access_stage with a behavioural
// memory responder and a byte-level reference model.
module tb_memory_access_stage;
    import riscv_pkg::*;

    localparam int unsigned AW = 32;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] sdata;
        logic        sel;
    } instr_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wb;
        logic        chk_wb;
        logic        fault;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] ALU_OUT;
    logic [4:0]  RD_ADDRESS_IN;
    logic [2:0]  DATA_CACHE_LOAD_IN;
    logic [1:0]  DATA_CACHE_STORE_IN;
    logic [31:0] DATA_CACHE_STORE_DATA;
    logic        WRITE_BACK_MUX_SELECT_IN;
    logic        RD_WRITE_ENABLE_IN;
    logic        STALL_PIPELINE;
    logic        MISALIGNED_FAULT;
    logic [4:0]  RD_ADDRESS_OUT;
    logic        RD_WRITE_ENABLE_OUT;
    logic [31:0] WB_DATA;

    memory_access_stage_if #(.ADDR_WIDTH(AW)) dmem ();

    memory_access_stage #(.ADDR_WIDTH(AW)) dut (
        .CLK                      (CLK),
        .RST_N                    (RST_N),
        .ALU_OUT                  (ALU_OUT),
        .RD_ADDRESS_IN            (RD_ADDRESS_IN),
        .DATA_CACHE_LOAD_IN       (DATA_CACHE_LOAD_IN),
        .DATA_CACHE_STORE_IN      (DATA_CACHE_STORE_IN),
        .DATA_CACHE_STORE_DATA    (DATA_CACHE_STORE_DATA),
        .WRITE_BACK_MUX_SELECT_IN (WRITE_BACK_MUX_SELECT_IN),
        .RD_WRITE_ENABLE_IN       (RD_WRITE_ENABLE_IN),
        .dmem                     (dmem),
        .STALL_PIPELINE           (STALL_PIPELINE),
        .MISALIGNED_FAULT         (MISALIGNED_FAULT),
        .RD_ADDRESS_OUT           (RD_ADDRESS_OUT),
        .RD_WRITE_ENABLE_OUT      (RD_WRITE_ENABLE_OUT),
        .WB_DATA                  (WB_DATA)
    );

    always #5 CLK = ~CLK;

    wb_exp_t     exp_q[$];
    req_exp_t    req_q[$];
    logic [31:0] mem [0:255];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          forced_lat = -1;
    logic        active     = 1'b0;
    logic        stall_seen = 1'b0;
    logic        due        = 1'b0;
    logic        bubble     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes (0 = no memory access); a valid load outranks a store
    function automatic int unsigned acc_size(input logic [2:0] ld, input logic [1:0] st);
        if (ld == LOAD_LB || ld == LOAD_LBU) return 1;
        if (ld == LOAD_LH || ld == LOAD_LHU) return 2;
        if (ld == LOAD_LW) return 4;
        if (st == STORE_SB) return 1;
        if (st == STORE_SH) return 2;
        if (st == STORE_SW) return 4;
        return 0;
    endfunction

    // Lowest byte lane touched: the offset rounded down to the access size
    function automatic int unsigned first_lane(input int unsigned size, input logic [1:0] o);
        int unsigned ov;
        ov = 32'(o);
        return (ov / size) * size;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] ld, input logic [31:0] word,
                                               input int unsigned lane, input int unsigned size);
        logic [31:0] sh;
        logic        sgn;
        sh  = word >> (8 * lane);
        sgn = (ld == LOAD_LB) || (ld == LOAD_LH);
        if (size == 1) return sgn ? 32'($signed(sh[7:0]))  : 32'(sh[7:0]);
        if (size == 2) return sgn ? 32'($signed(sh[15:0])) : 32'(sh[15:0]);
        return word;
    endfunction

    function automatic instr_t mk(input logic [31:0] alu, input logic [4:0] rd, input logic we,
                                  input logic [2:0] ld, input logic [1:0] st,
                                  input logic [31:0] sd, input logic sel);
        instr_t i;
        i.alu = alu; i.rd = rd; i.we = we; i.ld = ld; i.st = st; i.sdata = sd; i.sel = sel;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      i;
        int unsigned kind;
        kind    = $urandom_range(0, 2);
        i.rd    = 5'($urandom);
        i.we    = 1'($urandom);
        i.sdata = $urandom;
        i.alu   = 32'($urandom_range(0, 1023));
        i.st    = STORE_NONE;
        i.sel   = WB_SEL_ALU;
        case (kind)
            0: begin
                i.alu = $urandom;
                i.ld  = 3'($urandom_range(0, 2));
                if (i.ld != 3'd0) i.ld = 3'(i.ld + 3'd5);
                i.sel = 1'($urandom);
            end
            1: begin
                i.ld  = 3'($urandom_range(1, 5));
                i.st  = 2'($urandom);
                i.sel = ($urandom_range(0, 3) != 0) ? WB_SEL_MEM : WB_SEL_ALU;
            end
            default: begin
                i.ld = LOAD_NONE;
                i.st = 2'($urandom_range(1, 3));
            end
        endcase
        return i;
    endfunction

    // Drive one instruction once the stage is free and queue its expected effects
    task automatic issue(input instr_t in);
        int          guard;
        int unsigned size;
        int unsigned lane;
        logic [1:0]  o;
        logic        ld_ok;
        logic        mis;
        wb_exp_t     e;
        req_exp_t    r;
        logic [7:0]  widx;
        guard = 0;
        do begin
            @(posedge CLK);
            #1;
            guard++;
        end while (stall_seen && guard < 64);
        if (stall_seen) begin
            $display("FAIL stall_timeout: actual stall still high after %0d cycles required release", guard);
            $fatal(1, "stage never released the pipeline");
        end
        ALU_OUT                  = in.alu;
        RD_ADDRESS_IN            = in.rd;
        RD_WRITE_ENABLE_IN       = in.we;
        DATA_CACHE_LOAD_IN       = in.ld;
        DATA_CACHE_STORE_IN      = in.st;
        DATA_CACHE_STORE_DATA    = in.sdata;
        WRITE_BACK_MUX_SELECT_IN = in.sel;

        o     = in.alu[1:0];
        widx  = in.alu[9:2];
        ld_ok = is_load_op(in.ld);
        size  = acc_size(in.ld, in.st);
        lane  = (size == 0) ? 0 : first_lane(size, o);
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (size != 0) mis = ((32'(o) % size) != 0);
`endif
        e.rd     = in.rd;
        e.we     = in.we && !mis;
        e.fault  = mis;
        e.chk_wb = !mis;
        e.wb     = in.alu;
        if (ld_ok && !mis && in.sel) e.wb = load_model(in.ld, mem[widx], lane, size);
        if (size != 0 && !mis) begin
            r.addr  = {in.alu[31:2], 2'b00};
            r.we    = !ld_ok;
            r.wstrb = 4'b0000;
            r.wdata = 32'h0;
            if (!ld_ok) begin
                r.wstrb = 4'(((1 << size) - 1) << lane);
                if (size == 1)      r.wdata = {4{in.sdata[7:0]}};
                else if (size == 2) r.wdata = {2{in.sdata[15:0]}};
                else                r.wdata = in.sdata;
                for (int b = 0; b < 4; b++)
                    if (r.wstrb[b]) mem[widx][8*b +: 8] = r.wdata[8*b +: 8];
            end
            req_q.push_back(r);
        end
        exp_q.push_back(e);
        active = 1'b1;
    endtask

    // Write-back monitor: retire on non-stall cycles, expect bubbles on stall cycles
    always @(negedge CLK) begin
        wb_exp_t e;
        if (active && due) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: actual retirement required none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd_addr", 32'(RD_ADDRESS_OUT), 32'(e.rd));
                chk("wb_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'(e.we));
                chk("misaligned_fault", 32'(MISALIGNED_FAULT), 32'(e.fault));
                if (e.chk_wb) chk("wb_data", WB_DATA, e.wb);
            end
        end else if (active && bubble) begin
            chk("bubble_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'h0);
        end
        due        = active && !STALL_PIPELINE;
        bubble     = active && STALL_PIPELINE;
        stall_seen = STALL_PIPELINE;
    end

    // Memory responder: checks request payload, stalls a chosen number of cycles
    initial begin
        req_exp_t cur;
        int       lat;
        logic     busy;
        busy = 1'b0;
        lat  = 0;
        cur.addr = '0; cur.we = 1'b0; cur.wstrb = '0; cur.wdata = '0;
        dmem.DMEM_READY = 1'b0;
        dmem.DMEM_RDATA = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (!RST_N) begin
                busy            = 1'b0;
                dmem.DMEM_READY = 1'b0;
            end else if (dmem.DMEM_REQ) begin
                if (!busy) begin
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: actual request to 0x%08h required none", dmem.DMEM_ADDR);
                        cur.addr  = dmem.DMEM_ADDR;
                        cur.we    = dmem.DMEM_WE;
                        cur.wstrb = dmem.DMEM_WSTRB;
                        cur.wdata = dmem.DMEM_WDATA;
                    end else begin
                        cur = req_q.pop_front();
                        chk("req_addr", dmem.DMEM_ADDR, cur.addr);
                        chk("req_we", 32'(dmem.DMEM_WE), 32'(cur.we));
                        if (cur.we) begin
                            chk("req_wstrb", 32'(dmem.DMEM_WSTRB), 32'(cur.wstrb));
                            chk("req_wdata", dmem.DMEM_WDATA, cur.wdata);
                        end
                    end
                    busy = 1'b1;
                    lat  = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
                end else begin
                    chk("hold_addr", dmem.DMEM_ADDR, cur.addr);
                    chk("hold_we", 32'(dmem.DMEM_WE), 32'(cur.we));
                    if (cur.we) begin
                        chk("hold_wstrb", 32'(dmem.DMEM_WSTRB), 32'(cur.wstrb));
                        chk("hold_wdata", dmem.DMEM_WDATA, cur.wdata);
                    end
                end
                if (lat == 0) begin
                    dmem.DMEM_READY = 1'b1;
                    dmem.DMEM_RDATA = mem[cur.addr[9:2]];
                    busy            = 1'b0;
                end else begin
                    dmem.DMEM_READY = 1'b0;
                    dmem.DMEM_RDATA = $urandom;
                    lat--;
                end
            end else begin
                if (busy) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_dropped: actual req 0 required 1 at %0t", $time);
                    busy = 1'b0;
                end
                dmem.DMEM_READY = 1'($urandom_range(0, 1));
                dmem.DMEM_RDATA = $urandom;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(dmem.DMEM_REQ), 32'h0);
        chk({tag, "_stall"}, 32'(STALL_PIPELINE), 32'h0);
        chk({tag, "_rd_addr"}, 32'(RD_ADDRESS_OUT), 32'h0);
        chk({tag, "_rd_we"}, 32'(RD_WRITE_ENABLE_OUT), 32'h0);
        chk({tag, "_wb_data"}, WB_DATA, 32'h0);
        chk({tag, "_fault"}, 32'(MISALIGNED_FAULT), 32'h0);
    endtask

    task automatic drive_idle();
        ALU_OUT                  = '0;
        RD_ADDRESS_IN            = '0;
        RD_WRITE_ENABLE_IN       = 1'b0;
        DATA_CACHE_LOAD_IN       = LOAD_NONE;
        DATA_CACHE_STORE_IN      = STORE_NONE;
        DATA_CACHE_STORE_DATA    = '0;
        WRITE_BACK_MUX_SELECT_IN = WB_SEL_ALU;
    endtask

    initial begin
        drive_idle();
        RST_N = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #2 RST_N = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;

        // ALU pass-through
        issue(mk(32'h0000_0003, 5'd5, 1'b1, LOAD_NONE, STORE_NONE, 32'h0, WB_SEL_ALU));
        // Zero-wait byte loads, signed and unsigned
        mem[8'h40] = 32'h1280_3456;
        forced_lat = 0;
        issue(mk(32'h0000_0102, 5'd6, 1'b1, LOAD_LB,  STORE_NONE, 32'h0, WB_SEL_MEM));
        issue(mk(32'h0000_0102, 5'd7, 1'b1, LOAD_LBU, STORE_NONE, 32'h0, WB_SEL_MEM));
        // Half store with three wait cycles
        forced_lat = 3;
        issue(mk(32'h0000_0202, 5'd0, 1'b0, LOAD_NONE, STORE_SH, 32'h0000_ABCD, WB_SEL_ALU));
        // Back-to-back word load and store, then read the store back
        forced_lat = 0;
        issue(mk(32'h0000_0040, 5'd8, 1'b1, LOAD_LW, STORE_NONE, 32'h0, WB_SEL_MEM));
        issue(mk(32'h0000_0044, 5'd0, 1'b0, LOAD_NONE, STORE_SW, 32'hDEAD_BEEF, WB_SEL_ALU));
        issue(mk(32'h0000_0044, 5'd9, 1'b1, LOAD_LW, STORE_NONE, 32'h0, WB_SEL_MEM));
        // Word load at an unaligned address
        forced_lat = -1;
        issue(mk(32'h0000_0101, 5'd10, 1'b1, LOAD_LW, STORE_NONE, 32'h0, WB_SEL_MEM));
        issue(mk(32'h0000_0203, 5'd11, 1'b1, LOAD_LHU, STORE_NONE, 32'h0, WB_SEL_MEM));

        repeat (300) issue(rand_instr());
        issue(mk(32'h0000_1111, 5'd1, 1'b1, LOAD_NONE, STORE_NONE, 32'h0, WB_SEL_ALU));

        // Reset while a load is waiting
        forced_lat = 20;
        issue(mk(32'h0000_0080, 5'd12, 1'b1, LOAD_LW, STORE_NONE, 32'h0, WB_SEL_MEM));
        repeat (3) @(posedge CLK);
        #3;
        chk("stall_before_reset", 32'(STALL_PIPELINE), 32'h1);
        active = 1'b0;
        RST_N  = 1'b0;
        #1 chk_all_zero("reset_in_wait");
        drive_idle();
        exp_q.delete();
        req_q.delete();
        forced_lat = -1;
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        issue(mk(32'h0000_1234, 5'd13, 1'b1, LOAD_NONE, STORE_NONE, 32'h0, WB_SEL_ALU));
        issue(mk(32'h0000_0080, 5'd14, 1'b1, LOAD_LH, STORE_NONE, 32'h0, WB_SEL_MEM));
        repeat (20) issue(rand_instr());
        issue(mk(32'h0000_5555, 5'd15, 1'b1, LOAD_NONE, STORE_NONE, 32'h0, WB_SEL_ALU));
        repeat (2) @(negedge CLK);
        #1 active = 1'b0;

        chk("wb_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("req_queue_drained", 32'(req_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
